// File: rtl/packet_eject_sink_if.sv
// Purpose : ejection link from a router output port into the local sink.
// Latency : wires only; no storage in the interface.
// Backpr. : backpressure_wr is registered by the sink; the router stalls while it is 1.
// Ports   : link_in (packet, bit 48 = VALID), backpressure_wr (sink -> router stall).
interface packet_eject_sink_if #(
  parameter int PACKET_SIZE = 49
);
  logic [PACKET_SIZE-1:0] link_in;
  logic                   backpressure_wr;

  // Router side drives packets and observes stall.
  modport master (output link_in, input backpressure_wr);
  // Sink side consumes packets and drives stall.
  modport slave  (input link_in, output backpressure_wr);
endinterface

// File: rtl/packet_eject_sink.sv
// Purpose : terminal sink; buffers ejected packets in a FIFO, drains at a fixed rate, keeps delivery stats.
// Latency : push visible in fifo_count next cycle; stats updated on the pop edge (visible the cycle after the pop).
// Backpr. : backpressure_wr registered from next occupancy; packets arriving to a full FIFO without a pop are dropped.
// Ports   : clk, rst (sync, active high), clk_counter (global cycle count), link (slave modport:
//           link_in / backpressure_wr), total_packet_recieve, total_latency, max_latency,
//           misroute_cnt, drop_cnt, fifo_count.
module packet_eject_sink #(
  parameter int ROUTER_ID        = 0,
  parameter int PACKET_SIZE      = 49,
  parameter int BUFFER_SIZE      = 4,
  parameter int DRAIN_CYCLE      = 1,
  parameter int BUFFER_THRESHOLD = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   clk_counter,
  packet_eject_sink_if.slave            link,
  output logic [63:0]                   total_packet_recieve,
  output logic [63:0]                   total_latency,
  output logic [15:0]                   max_latency,
  output logic [15:0]                   misroute_cnt,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(BUFFER_SIZE):0]  fifo_count
);

  localparam int PW  = $clog2(BUFFER_SIZE);
  localparam int CW  = PW + 1;
  localparam int TW  = (DRAIN_CYCLE > 1) ? $clog2(DRAIN_CYCLE) : 1;
  localparam int VLD = 48;
  localparam logic [15:0] MY_ID = 16'(ROUTER_ID);

  // Storage and control state
  logic [PACKET_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          count_q, count_d;
  logic [TW-1:0]          timer_q;
  logic                   bp_q, bp_d;

  // Statistics
  logic [63:0] recv_q, lat_sum_q;
  logic [15:0] max_lat_q, misroute_q, drop_q;

  // Per-cycle decisions
  logic        push, pop_opp, pop, full, push_acc, drop;
  logic [15:0] head_ts, head_dst, lat;
  logic [31:0] free_slots;

  always_comb begin
    push     = link.link_in[VLD];
    pop_opp  = (timer_q == TW'(DRAIN_CYCLE - 1));
    // Pop decision uses occupancy at the start of the cycle, so a packet
    // pushed into an empty FIFO is never popped in the same cycle.
    pop      = pop_opp && (count_q != '0);
    full     = (count_q == CW'(BUFFER_SIZE));
    // A pop frees the head slot this edge, so a full FIFO still accepts.
    push_acc = push && (!full || pop);
    drop     = push && full && !pop;

    head_ts  = mem_q[head_q][47:32];
    head_dst = mem_q[head_q][15:0];
    // Modulo-2^16 difference tolerates clk_counter wrap-around.
    lat      = clk_counter - head_ts;

    count_d = count_q;
    if (push_acc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_acc && pop) begin
      count_d = count_q - CW'(1);
    end

    free_slots = 32'(BUFFER_SIZE) - 32'(count_d);
    bp_d       = (free_slots < 32'(BUFFER_THRESHOLD));
  end

  // FIFO storage. The pop clears VALID before the push write so that a
  // push+pop on a full FIFO (head == tail) keeps the new packet intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        mem_q[head_q][VLD] <= 1'b0;
      end
      if (push_acc) begin
        mem_q[tail_q] <= link.link_in;
      end
    end
  end

  // Pointers, occupancy, drain timer, backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      bp_q    <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      if (push_acc) begin
        tail_q <= tail_q + PW'(1);
      end
      count_q <= count_d;
      timer_q <= pop_opp ? '0 : timer_q + TW'(1);
      bp_q    <= bp_d;
    end
  end

  // Statistics, updated on the pop/drop edge
  always_ff @(posedge clk) begin
    if (rst) begin
      recv_q     <= '0;
      lat_sum_q  <= '0;
      max_lat_q  <= '0;
      misroute_q <= '0;
      drop_q     <= '0;
    end else begin
      if (pop) begin
        if (head_dst == MY_ID) begin
          recv_q    <= recv_q + 64'd1;
          lat_sum_q <= lat_sum_q + {48'd0, lat};
          if (lat > max_lat_q) begin
            max_lat_q <= lat;
          end
        end else if (misroute_q != 16'hFFFF) begin
          misroute_q <= misroute_q + 16'd1;
        end
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign link.backpressure_wr = bp_q;
  assign total_packet_recieve = recv_q;
  assign total_latency        = lat_sum_q;
  assign max_latency          = max_lat_q;
  assign misroute_cnt         = misroute_q;
  assign drop_cnt             = drop_q;
  assign fifo_count           = count_q;

endmodule
